// File: rtl/timer_irq_controller.sv
// Prioritising interrupt controller: captures timer falling edges as sticky pending bits,
// masks them, and presents the lowest-index enabled source to the CPU until acknowledged.
module timer_irq_controller #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               WE_L,
  input  logic               AS_L,
  input  logic               status_reg_select,
  input  logic               mask_reg_select,
  input  logic               vector_reg_select,
  input  logic [31:0]        data_in,
  output logic [31:0]        data_out,
  input  logic [NUM_SRC-1:0] irq_in_n,
  input  logic               irq_ack,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    irq_id,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  pending_q, mask_q, prev_n_q;
  logic [NUM_SRC-1:0]  fall, w1c, ack_clr, active_bits, cur_bits;
  logic [ID_W-1:0]     lowest_id, irq_id_d;
  logic                cpu_irq_d;
  logic                bus_wr, bus_rd, any_sel;
  logic [31:0]         rd_data;

  assign bus_wr      = !AS_L && !WE_L;
  assign bus_rd      = !AS_L && WE_L;
  assign any_sel     = status_reg_select || mask_reg_select || vector_reg_select;
  assign fall        = prev_n_q & ~irq_in_n;
  assign w1c         = (bus_wr && status_reg_select) ? data_in[NUM_SRC-1:0] : '0;
  assign active_bits = pending_q & mask_q;
  assign cur_bits    = active_bits >> irq_id;
  assign dbg_state   = state_q;

  always_comb begin
    lowest_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active_bits[i]) lowest_id = ID_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    cpu_irq_d = cpu_irq;
    irq_id_d  = irq_id;
    ack_clr   = '0;
    case (state_q)
      IDLE: begin
        if (|active_bits) begin
          irq_id_d  = lowest_id;
          cpu_irq_d = 1'b1;
          state_d   = ACTIVE;
        end else begin
          cpu_irq_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (irq_ack) begin
          ack_clr   = NUM_SRC'(1) << irq_id;
          cpu_irq_d = 1'b0;
          state_d   = HOLDOFF;
        end else if (!cur_bits[0]) begin
          // Software cleared or masked the presented source: withdraw the request.
          cpu_irq_d = 1'b0;
          state_d   = IDLE;
        end
      end
      HOLDOFF: begin
        cpu_irq_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        cpu_irq_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_data = data_out;
    if (status_reg_select)      rd_data = 32'(pending_q);
    else if (mask_reg_select)   rd_data = 32'(mask_q);
    else if (vector_reg_select) rd_data = {cpu_irq, {(31-ID_W){1'b0}}, irq_id};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      // Track the lines during reset so a line already low at release is not an edge.
      prev_n_q  <= irq_in_n;
      cpu_irq   <= 1'b0;
      irq_id    <= '0;
      data_out  <= '0;
    end else begin
      state_q   <= state_d;
      cpu_irq   <= cpu_irq_d;
      irq_id    <= irq_id_d;
      prev_n_q  <= irq_in_n;
      // New edges override same-cycle clears from software or acknowledge.
      pending_q <= (pending_q & ~(w1c | ack_clr)) | fall;
      if (bus_wr && mask_reg_select) mask_q <= data_in[NUM_SRC-1:0];
      if (bus_rd && any_sel) data_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_timer_irq_controller.sv
// Self-checking bench for timer_irq_controller: per-cycle reference model comparison
// plus directed scenarios with literal expectations.
module tb_timer_irq_controller;

  localparam int N  = 8;
  localparam int IW = 4;
  localparam logic [2:0] S_STAT = 3'b100;
  localparam logic [2:0] S_MASK = 3'b010;
  localparam logic [2:0] S_VEC  = 3'b001;

  logic          clk;
  logic          reset;
  logic          WE_L, AS_L;
  logic          status_reg_select, mask_reg_select, vector_reg_select;
  logic [31:0]   data_in, data_out;
  logic [N-1:0]  irq_in_n;
  logic          irq_ack;
  logic          cpu_irq;
  logic [IW-1:0] irq_id;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  timer_irq_controller #(.NUM_SRC(N), .ID_W(IW)) dut (
    .clk(clk), .reset(reset), .WE_L(WE_L), .AS_L(AS_L),
    .status_reg_select(status_reg_select), .mask_reg_select(mask_reg_select),
    .vector_reg_select(vector_reg_select), .data_in(data_in), .data_out(data_out),
    .irq_in_n(irq_in_n), .irq_ack(irq_ack), .cpu_irq(cpu_irq), .irq_id(irq_id),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // reference model: phase 0 = waiting, 1 = presenting, 2 = mandatory low cycle
  logic [N-1:0]  m_pend, m_mask, m_prev, clr;
  logic          m_cpu;
  logic [IW-1:0] m_id;
  logic [31:0]   m_dout;
  int            m_phase;
  logic          wr, rd;

  function automatic logic [IW-1:0] first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return IW'(i);
    return '0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pend = '0; m_mask = '0; m_prev = irq_in_n;
      m_cpu = 1'b0; m_id = '0; m_dout = '0; m_phase = 0;
    end else begin
      wr  = !AS_L && !WE_L;
      rd  = !AS_L && WE_L;
      clr = (wr && status_reg_select) ? data_in[N-1:0] : '0;
      if (rd) begin
        if (status_reg_select)      m_dout = {24'd0, m_pend};
        else if (mask_reg_select)   m_dout = {24'd0, m_mask};
        else if (vector_reg_select) m_dout = {m_cpu, 27'd0, m_id};
      end
      case (m_phase)
        0: if ((m_pend & m_mask) != 0) begin
             m_id = first_set(m_pend & m_mask); m_cpu = 1'b1; m_phase = 1;
           end
        1: if (irq_ack) begin
             clr = clr | (N'(1) << m_id); m_cpu = 1'b0; m_phase = 2;
           end else if (!(m_pend[m_id] && m_mask[m_id])) begin
             m_cpu = 1'b0; m_phase = 0;
           end
        default: m_phase = 0;
      endcase
      m_pend = (m_pend & ~clr) | (m_prev & ~irq_in_n);
      if (wr && mask_reg_select) m_mask = data_in[N-1:0];
      m_prev = irq_in_n;
    end
    #1;
    check("cyc_cpu_irq", {31'd0, cpu_irq}, {31'd0, m_cpu});
    check("cyc_irq_id", {28'd0, irq_id}, {28'd0, m_id});
    check("cyc_data_out", data_out, m_dout);
    check("cyc_state", {30'd0, dbg_state}, 32'(m_phase));
  end

  // driver tasks (called at negedge; each returns at a negedge)
  task automatic idle_bus();
    AS_L = 1'b1; WE_L = 1'b1;
    {status_reg_select, mask_reg_select, vector_reg_select} = 3'b000;
    data_in = '0;
  endtask

  task automatic bus_write(input logic [2:0] sel, input logic [31:0] d);
    AS_L = 1'b0; WE_L = 1'b0;
    {status_reg_select, mask_reg_select, vector_reg_select} = sel;
    data_in = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic bus_read(input logic [2:0] sel);
    AS_L = 1'b0; WE_L = 1'b1;
    {status_reg_select, mask_reg_select, vector_reg_select} = sel;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_in_n = '1; irq_ack = 1'b0;
    idle_bus();
    repeat (2) @(negedge clk);
    check("rst_cpu_irq", {31'd0, cpu_irq}, 32'd0);
    check("rst_irq_id", {28'd0, irq_id}, 32'd0);
    check("rst_data_out", data_out, 32'd0);
    reset = 1'b0;

    // single source, latency and acknowledge
    bus_write(S_MASK, 32'h01);
    irq_in_n[0] = 1'b0;
    @(negedge clk);
    bus_read(S_STAT);
    check("s1_pending", data_out, 32'h01);
    check("s1_cpu_irq", {31'd0, cpu_irq}, 32'd1);
    check("s1_irq_id", {28'd0, irq_id}, 32'd0);
    @(negedge clk);
    ack_pulse();
    check("s1_ack_drop", {31'd0, cpu_irq}, 32'd0);
    irq_in_n[0] = 1'b1;
    bus_read(S_STAT);
    check("s1_pending_clr", data_out, 32'h00);
    @(negedge clk);

    // two simultaneous sources, priority and holdoff
    bus_write(S_MASK, 32'hFF);
    irq_in_n[5] = 1'b0; irq_in_n[2] = 1'b0;
    repeat (2) @(negedge clk);
    check("s2_first_cpu", {31'd0, cpu_irq}, 32'd1);
    check("s2_first_id", {28'd0, irq_id}, 32'd2);
    ack_pulse();
    check("s2_ack_drop", {31'd0, cpu_irq}, 32'd0);
    @(negedge clk);
    check("s2_holdoff_low", {31'd0, cpu_irq}, 32'd0);
    @(negedge clk);
    check("s2_second_cpu", {31'd0, cpu_irq}, 32'd1);
    check("s2_second_id", {28'd0, irq_id}, 32'd5);
    ack_pulse();
    irq_in_n[5] = 1'b1; irq_in_n[2] = 1'b1;
    repeat (2) @(negedge clk);

    // held-low line while masked, then unmask
    bus_write(S_MASK, 32'h00);
    irq_in_n[3] = 1'b0;
    repeat (20) @(negedge clk);
    check("s3_masked_low", {31'd0, cpu_irq}, 32'd0);
    bus_read(S_STAT);
    check("s3_pending_once", data_out, 32'h08);
    bus_write(S_MASK, 32'h08);
    check("s3_not_yet", {31'd0, cpu_irq}, 32'd0);
    @(negedge clk);
    check("s3_cpu_irq", {31'd0, cpu_irq}, 32'd1);
    check("s3_irq_id", {28'd0, irq_id}, 32'd3);
    ack_pulse();
    irq_in_n[3] = 1'b1;
    @(negedge clk);

    // software withdraws the presented request
    bus_write(S_MASK, 32'hFF);
    irq_in_n[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("s4_cpu_irq", {31'd0, cpu_irq}, 32'd1);
    check("s4_irq_id", {28'd0, irq_id}, 32'd1);
    bus_write(S_STAT, 32'h02);
    @(negedge clk);
    check("s4_withdrawn", {31'd0, cpu_irq}, 32'd0);
    check("s4_state_idle", {30'd0, dbg_state}, 32'd0);
    bus_read(S_STAT);
    check("s4_pending", data_out, 32'h00);
    irq_in_n[1] = 1'b1;
    @(negedge clk);

    // set beats same-cycle clear; vector read
    irq_in_n[4] = 1'b0;
    AS_L = 1'b0; WE_L = 1'b0; status_reg_select = 1'b1; data_in = 32'h10;
    @(negedge clk);
    idle_bus();
    bus_read(S_STAT);
    check("s5_set_wins", data_out, 32'h10);
    bus_read(S_VEC);
    check("s5_vector", data_out, 32'h8000_0004);

    // reset while presenting, line still low at release
    reset = 1'b1;
    @(negedge clk);
    check("s6_rst_cpu", {31'd0, cpu_irq}, 32'd0);
    check("s6_rst_id", {28'd0, irq_id}, 32'd0);
    check("s6_rst_dout", data_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus_read(S_MASK);
    check("s6_mask_rst", data_out, 32'h00);
    bus_write(S_MASK, 32'hABCD_EF5A);
    bus_read(S_MASK);
    check("s6_mask_upper", data_out, 32'h5A);
    repeat (3) @(negedge clk);
    check("s6_no_edge", {31'd0, cpu_irq}, 32'd0);
    bus_read(S_STAT);
    check("s6_pending", data_out, 32'h00);
    irq_in_n[4] = 1'b1;
    @(negedge clk);
    irq_in_n[4] = 1'b0;
    repeat (2) @(negedge clk);
    check("s6_rearm_cpu", {31'd0, cpu_irq}, 32'd1);
    check("s6_rearm_id", {28'd0, irq_id}, 32'd4);
    bus_read(3'b111);
    check("s6_rd_prio_stat", data_out, 32'h10);
    bus_read(3'b011);
    check("s6_rd_prio_mask", data_out, 32'h5A);
    ack_pulse();
    irq_in_n = '1;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
